// File: rtl/sd_request_arbiter.sv
// Round-robin arbiter sharing one SD sector engine between NREQ requesters.
// Each requester sees a private request/done/byte-strobe port; the engine sees one requester.
module sd_request_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  output logic [NREQ-1:0]      req_busy,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      req_byte_strobe,
  output logic [2:0]           grant_idx,
  output logic                 grant_valid,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_busy,
  input  logic                 sd_done,
  input  logic                 sd_rd_byte_strobe
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RELEASE   = 3'd4;

  logic [2:0]      state;
  logic [2:0]      rr_ptr;
  logic [2:0]      next_ptr;
  logic            op_rd;
  logic [23:0]     tmo_cnt;

  logic [NREQ-1:0] req_rd_p0;
  logic [NREQ-1:0] req_wr_p0;
  logic [NREQ-1:0] rd_edge;
  logic [NREQ-1:0] wr_edge;
  logic [NREQ-1:0] pend_rd;
  logic [NREQ-1:0] pend_wr;
  logic [NREQ-1:0] clr_rd;
  logic [NREQ-1:0] clr_wr;
  logic [NREQ-1:0] grant_oh;

  logic [7:0]      pend_any8;
  logic [7:0]      pend_rd8;
  logic            scan_hit;
  logic [2:0]      scan_idx;
  logic [31:0]     lba_arr [8];

  // Pad the LBA bus out to eight slots so a 3-bit grant index always selects cleanly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lba
    if (gi < NREQ) begin : g_used
      assign lba_arr[gi] = req_lba[32*gi +: 32];
    end else begin : g_pad
      assign lba_arr[gi] = 32'd0;
    end
  end

  assign rd_edge   = req_rd & ~req_rd_p0;
  assign wr_edge   = req_wr & ~req_wr_p0;
  assign pend_any8 = 8'(pend_rd | pend_wr);
  assign pend_rd8  = 8'(pend_rd);
  assign next_ptr  = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = (grant_idx == 3'(i));
    end
  end

  // Walk from the farthest offset down so the requester nearest the pointer wins.
  always_comb begin
    int c;
    c        = 0;
    scan_hit = 1'b0;
    scan_idx = 3'd0;
    for (int k = NREQ-1; k >= 0; k--) begin
      c = int'(rr_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (pend_any8[3'(c)]) begin
        scan_hit = 1'b1;
        scan_idx = 3'(c);
      end
    end
  end

  always_comb begin
    clr_rd = '0;
    clr_wr = '0;
    if (state == ISSUE) begin
      if (op_rd) clr_rd = grant_oh;
      else       clr_wr = grant_oh;
    end
  end

  assign req_byte_strobe = (state == WAIT_DONE && sd_rd_byte_strobe) ? grant_oh : '0;

  // Request capture stage: registered input copies and sticky pending flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_rd_p0 <= '0;
      req_wr_p0 <= '0;
      pend_rd   <= '0;
      pend_wr   <= '0;
    end else begin
      req_rd_p0 <= req_rd;
      req_wr_p0 <= req_wr;
      pend_rd   <= (pend_rd & ~clr_rd) | rd_edge;
      pend_wr   <= (pend_wr & ~clr_wr) | wr_edge;
    end
  end

  // Grant and engine handshake stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 3'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      op_rd       <= 1'b0;
      sd_lba      <= 32'd0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      req_done    <= '0;
      req_err     <= '0;
      req_busy    <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      req_busy <= pend_rd | pend_wr | (grant_valid ? grant_oh : '0);
      case (state)
        IDLE: begin
          if (scan_hit) begin
            grant_idx   <= scan_idx;
            sd_lba      <= lba_arr[scan_idx];
            grant_valid <= 1'b1;
            op_rd       <= pend_rd8[scan_idx];
            sd_rd       <= pend_rd8[scan_idx];
            sd_wr       <= ~pend_rd8[scan_idx];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A done coincident with busy is ignored here; WAIT_DONE re-samples it.
          if (sd_busy) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= WAIT_DONE;
          end else if (tmo_cnt <= 24'd1) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            req_err <= grant_oh;
            state   <= RELEASE;
          end
        end
        WAIT_DONE: begin
          if (sd_done) begin
            req_done <= grant_oh;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          grant_valid <= 1'b0;
          rr_ptr      <= next_ptr;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Timeout counter, loaded in ISSUE; the error fires TIMEOUT cycles after the load
  always_ff @(posedge clk) begin
    if (state == ISSUE) begin
      tmo_cnt <= TIMEOUT;
    end else if (state == WAIT_BUSY && tmo_cnt != 24'd0) begin
      tmo_cnt <= tmo_cnt - 24'd1;
    end
  end

endmodule
